sata_oobseq: RTL

//  Host-side OOB/link bring-up sequencer. Commands the OOB burst generator to send COMRESET/COMWAKE,

---
 rtl/sata_oobseq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sata_oobseq.sv
// Host-side OOB/link bring-up sequencer: COMRESET/COMWAKE requests, response timing, D10.2 -> ALIGN, link up.
// Optional build macro COMSEQ_RETRY_LIMIT_EN adds S_FAIL after MAX_RETRIES failed attempts.
module sata_oobseq #(
    parameter int INIT_TIMEOUT  = 2048,
    parameter int WAKE_TIMEOUT  = 2048,
    parameter int ALIGN_TIMEOUT = 65536,
    parameter int TW            = 17,
    parameter int RW            = 4,
    parameter int MAX_RETRIES   = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_restart,
    output logic          o_burst_valid,
    output logic          o_burst_type,
    input  logic          i_burst_ready,
    input  logic          i_burst_done,
    input  logic          i_cominit_det,
    input  logic          i_comwake_det,
    input  logic          i_rx_align,
    input  logic          i_rx_sync,
    output logic          o_tx_idle,
    output logic          o_tx_d102,
    output logic          o_tx_align,
    output logic          o_link_up,
    output logic [RW-1:0] o_retries,
    output logic          o_fail
);

    typedef enum logic [3:0] {
        S_IDLE, S_COMRESET, S_RST_TX, S_WAIT_INIT, S_COMWAKE, S_WAKE_TX,
        S_WAIT_WAKE, S_WAIT_ALIGN, S_SEND_ALIGN, S_READY
`ifdef COMSEQ_RETRY_LIMIT_EN
        , S_FAIL
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q;
    logic [RW-1:0] retries_q, retries_d;
    logic          timeout;
    logic          in_wait;

    assign in_wait = (state_q == S_WAIT_INIT) || (state_q == S_WAIT_WAKE) ||
                     (state_q == S_WAIT_ALIGN);

    // Priority is restart > detect > timeout; detects are only looked at in their own state.
    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        timeout   = 1'b0;
        case (state_q)
            S_IDLE:       state_d = S_COMRESET;
            S_COMRESET:   if (i_burst_ready) state_d = S_RST_TX;
            S_RST_TX:     if (i_burst_done) state_d = S_WAIT_INIT;
            S_WAIT_INIT: begin
                if (i_cominit_det) state_d = S_COMWAKE;
                else if (timer_q == TW'(INIT_TIMEOUT - 1)) timeout = 1'b1;
            end
            S_COMWAKE:    if (i_burst_ready) state_d = S_WAKE_TX;
            S_WAKE_TX:    if (i_burst_done) state_d = S_WAIT_WAKE;
            S_WAIT_WAKE: begin
                if (i_comwake_det) state_d = S_WAIT_ALIGN;
                else if (timer_q == TW'(WAKE_TIMEOUT - 1)) timeout = 1'b1;
            end
            S_WAIT_ALIGN: begin
                if (i_rx_align) state_d = S_SEND_ALIGN;
                else if (timer_q == TW'(ALIGN_TIMEOUT - 1)) timeout = 1'b1;
            end
            S_SEND_ALIGN: if (i_rx_sync) state_d = S_READY;
            S_READY:      if (i_cominit_det) state_d = S_COMRESET;
`ifdef COMSEQ_RETRY_LIMIT_EN
            S_FAIL:       state_d = S_FAIL;
`endif
            default:      state_d = S_IDLE;
        endcase

        if (timeout) begin
`ifdef COMSEQ_RETRY_LIMIT_EN
            if (retries_q == RW'(MAX_RETRIES - 1)) begin
                state_d   = S_FAIL;
                retries_d = RW'(MAX_RETRIES);
            end else begin
                state_d = S_COMRESET;
                if (retries_q != '1) retries_d = retries_q + 1'b1;
            end
`else
            state_d = S_COMRESET;
            if (retries_q != '1) retries_d = retries_q + 1'b1;
`endif
        end

        if ((state_d == S_READY) && (state_q != S_READY)) retries_d = '0;

        if (i_restart) begin
            state_d   = S_COMRESET;
            retries_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            retries_q <= '0;
        end else begin
            state_q   <= state_d;
            retries_q <= retries_d;
            // Timer restarts on every state change so occupancy on timeout equals the timeout value.
            if (i_restart || (state_d != state_q)) timer_q <= '0;
            else if (in_wait) timer_q <= timer_q + 1'b1;
        end
    end

    always_comb begin
        o_burst_valid = (state_q == S_COMRESET) || (state_q == S_COMWAKE);
        o_burst_type  = (state_q == S_COMWAKE);
        o_tx_d102     = (state_q == S_WAIT_ALIGN);
        o_tx_align    = (state_q == S_SEND_ALIGN);
        o_link_up     = (state_q == S_READY);
        o_tx_idle     = !(o_tx_d102 || o_tx_align || o_link_up);
    end

    assign o_retries = retries_q;

`ifdef COMSEQ_RETRY_LIMIT_EN
    assign o_fail = (state_q == S_FAIL);
`else
    logic [RW-1:0] unused_retry_limit;
    assign unused_retry_limit = RW'(MAX_RETRIES);
    assign o_fail = 1'b0;
`endif

endmodule
